// File: rtl/clyde_oser_pkg.sv
// Shared types and size derivation for the Clyde-128 output serializer.
package clyde_oser_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } oser_state_t;

    function automatic int oser_nwords(input int nbits, input int w);
        return nbits / w;
    endfunction

    function automatic int oser_idx_w(input int nbits, input int w);
        return $clog2(nbits / w);
    endfunction

endpackage

// File: rtl/clyde_out_serializer_if.sv
// Word stream from the serializer to the mode/interface logic (valid/ready).
interface clyde_out_serializer_if #(
    parameter int W = 32
);
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         dout_last;

    modport master (output dout, output dout_valid, output dout_last, input dout_ready);
    modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/clyde_oser_wordsel.sv
// Buffer-to-word multiplexer; CLYDE_OSER_MSW_FIRST_EN selects MSW-first ordering.
module clyde_oser_wordsel
    import clyde_oser_pkg::*;
#(
    parameter int Nbits = 128,
    parameter int W     = 32,
    localparam int NWORDS = oser_nwords(Nbits, W),
    localparam int IW     = oser_idx_w(Nbits, W)
) (
    input  logic [Nbits-1:0] buffer,
    input  logic [IW-1:0]    idx,
    output logic [W-1:0]     word
);

    logic [W-1:0] words [NWORDS];

    for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
`ifdef CLYDE_OSER_MSW_FIRST_EN
        assign words[gi] = buffer[Nbits-W*(gi+1) +: W];
`else
        assign words[gi] = buffer[W*gi +: W];
`endif
    end

    assign word = words[idx];

endmodule

// File: rtl/clyde_out_serializer.sv
// Captures the unmasked Clyde-128 output block and streams it as W-bit words.
// Word order is LSW first unless CLYDE_OSER_MSW_FIRST_EN is defined.
module clyde_out_serializer
    import clyde_oser_pkg::*;
#(
    parameter int Nbits = 128,
    parameter int W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pre_data_out_valid,
    input  logic [Nbits-1:0]      data_out,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clr_overrun,
    clyde_out_serializer_if.master stream
);

    localparam int NWORDS = oser_nwords(Nbits, W);
    localparam int IW     = oser_idx_w(Nbits, W);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    oser_state_t      state_reg;
    logic [IW-1:0]    idx_reg;
    logic [Nbits-1:0] buffer_reg;
    logic             busy_reg;
    logic             dout_valid_reg;
    logic             dout_last_reg;
    logic             overrun_reg;
    logic             cap_pend_reg;
    logic [W-1:0]     word;

    clyde_oser_wordsel #(
        .Nbits (Nbits),
        .W     (W)
    ) u_wordsel (
        .buffer (buffer_reg),
        .idx    (idx_reg),
        .word   (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            buffer_reg     <= '0;
            busy_reg       <= 1'b0;
            dout_valid_reg <= 1'b0;
            dout_last_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            cap_pend_reg   <= 1'b0;
        end else begin
            // A block arriving outside IDLE is lost; the set beats a same-cycle clear.
            if (pre_data_out_valid && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end else if (clr_overrun) begin
                overrun_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pre_data_out_valid) begin
                        cap_pend_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (cap_pend_reg) begin
                        buffer_reg <= data_out;
                    end
                    cap_pend_reg   <= 1'b0;
                    idx_reg        <= '0;
                    dout_valid_reg <= 1'b1;
                    dout_last_reg  <= (LAST_IDX == '0);
                    state_reg      <= SEND;
                end
                SEND: begin
                    if (stream.dout_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            idx_reg        <= '0;
                            busy_reg       <= 1'b0;
                            dout_valid_reg <= 1'b0;
                            dout_last_reg  <= 1'b0;
                            state_reg      <= IDLE;
                        end else begin
                            idx_reg       <= idx_reg + 1'b1;
                            dout_last_reg <= ((idx_reg + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    busy_reg       <= 1'b0;
                    dout_valid_reg <= 1'b0;
                    dout_last_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy              = busy_reg;
    assign overrun           = overrun_reg;
    assign stream.dout       = word;
    assign stream.dout_valid = dout_valid_reg;
    assign stream.dout_last  = dout_last_reg;

endmodule

// File: tb/tb_clyde_out_serializer.sv
// Directed bench for clyde_out_serializer; honours CLYDE_OSER_MSW_FIRST_EN word order.
module tb_clyde_out_serializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pre_data_out_valid = 1'b0;
    logic [127:0] data_out = '0;
    logic         clr_overrun = 1'b0;
    logic         busy;
    logic         overrun;

    int vectors = 0;
    int errors  = 0;

    // Hand-split LSW-first words of the two test blocks.
    logic [31:0] blk_a_words [4] = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    logic [31:0] blk_b_words [4] = '{32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};

    clyde_out_serializer_if #(.W(32)) stream ();

    clyde_out_serializer #(
        .Nbits (128),
        .W     (32)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pre_data_out_valid (pre_data_out_valid),
        .data_out           (data_out),
        .busy               (busy),
        .overrun            (overrun),
        .clr_overrun        (clr_overrun),
        .stream             (stream.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] words [4], input int k);
`ifdef CLYDE_OSER_MSW_FIRST_EN
        return words[3-k];
`else
        return words[k];
`endif
    endfunction

    task automatic chk_word(input string tag, input logic [31:0] words [4], input int k);
        chk1({tag, "_valid"}, stream.dout_valid, 1'b1);
        chkw({tag, "_dout"}, stream.dout, exp_word(words, k));
        chk1({tag, "_last"}, stream.dout_last, (k == 3) ? 1'b1 : 1'b0);
        chk1({tag, "_busy"}, busy, 1'b1);
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_valid"}, stream.dout_valid, 1'b0);
        chk1({tag, "_last"}, stream.dout_last, 1'b0);
    endtask

    // One-cycle pulse in IDLE; returns in the CAPTURE cycle.
    task automatic pulse();
        pre_data_out_valid = 1'b1;
        tick();
        pre_data_out_valid = 1'b0;
    endtask

    initial begin
        stream.dout_ready = 1'b1;
        #2;
        chk_idle("rst");
        chkw("rst_dout", stream.dout, 32'h0);
        chk1("rst_overrun", overrun, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Nominal streaming with consumer always ready
        data_out = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        tick();
        pulse();
        chk1("nom_cap_busy", busy, 1'b1);
        chk1("nom_cap_valid", stream.dout_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_word($sformatf("nom_w%0d", k), blk_a_words, k);
        end
        tick();
        chk_idle("nom_done");
        chk1("nom_overrun", overrun, 1'b0);

        // Backpressure on word1 for three cycles
        tick();
        pulse();
        tick();
        chk_word("bp_w0", blk_a_words, 0);
        tick();
        stream.dout_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_word($sformatf("bp_hold%0d", c), blk_a_words, 1);
            tick();
        end
        stream.dout_ready = 1'b1;
        chk_word("bp_w1", blk_a_words, 1);
        tick();
        chk_word("bp_w2", blk_a_words, 2);
        tick();
        chk_word("bp_w3", blk_a_words, 3);
        tick();
        chk_idle("bp_done");

        // Second pulse while streaming (t+3) sets overrun, first block intact
        tick();
        pulse();
        tick();
        chk_word("ov_w0", blk_a_words, 0);
        tick();
        chk_word("ov_w1", blk_a_words, 1);
        data_out = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
        pre_data_out_valid = 1'b1;
        tick();
        pre_data_out_valid = 1'b0;
        chk1("ov_set", overrun, 1'b1);
        chk_word("ov_w2", blk_a_words, 2);
        tick();
        chk_word("ov_w3", blk_a_words, 3);
        chk1("ov_sticky", overrun, 1'b1);
        tick();
        chk_idle("ov_done");
        chk1("ov_sticky_idle", overrun, 1'b1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk1("ov_clr", overrun, 1'b0);

        // Set wins over a same-cycle clear
        data_out = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        tick();
        pulse();
        pre_data_out_valid = 1'b1;
        clr_overrun = 1'b1;
        tick();
        pre_data_out_valid = 1'b0;
        clr_overrun = 1'b0;
        chk1("setclr_overrun", overrun, 1'b1);
        chk_word("setclr_w0", blk_a_words, 0);
        for (int k = 0; k < 4; k++) tick();
        chk_idle("setclr_done");
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk1("setclr_clr", overrun, 1'b0);

        // Asynchronous reset mid-SEND, after word1, with overrun pending
        tick();
        pulse();
        tick();
        chk_word("rs_w0", blk_a_words, 0);
        pre_data_out_valid = 1'b1;
        tick();
        pre_data_out_valid = 1'b0;
        chk_word("rs_w1", blk_a_words, 1);
        chk1("rs_overrun_pre", overrun, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rs_async");
        chkw("rs_dout", stream.dout, 32'h0);
        chk1("rs_overrun", overrun, 1'b0);
        tick();
        chk_idle("rs_held");
        rst_n = 1'b1;
        tick();

        // Fresh block streams from word0 after reset
        data_out = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
        pulse();
        chk1("nb_cap_busy", busy, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_word($sformatf("nb_w%0d", k), blk_b_words, k);
        end
        tick();
        chk_idle("nb_done");
        chk1("nb_overrun", overrun, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/clyde_out_serializer.md
# clyde_out_serializer

Output-side stage directly downstream of the masked Clyde-128 top. Captures the recombined, unmasked 128-bit block the core produces when it flags output valid, then streams it to the mode/interface logic as W-bit words over a valid/ready handshake. Asserts a busy flag toward the stalling logic so no new Clyde run starts while a block is still draining, and flags overruns when a block is lost.

## Interface
Parameters:
- Nbits, 128, block width; multiple of W
- W, 32, output word width; Nbits/W must be a power of two ≥ 2

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pre_data_out_valid  in  1  core output-valid flag, high one cycle before data_out is stable
- data_out  in  Nbits  recombined block from the core
- busy  out  1  buffer occupied; gates start of next core run
- dout  out  W  output word
- dout_valid  out  1  dout holds a valid word
- dout_ready  in  1  consumer accepts dout
- dout_last  out  1  dout is the final word of the block
- overrun  out  1  sticky: a block arrived while busy
- clr_overrun  in  1  synchronous clear of overrun

## Operation
- NWORDS = Nbits/W; word counter idx, width log2(NWORDS), wraps naturally.
- Reset (async, rst_n=0): state IDLE, idx=0, buffer=0, busy=0, dout_valid=0, dout_last=0, dout=0, overrun=0, cap_pend=0.
- FSM states:
  - IDLE: if pre_data_out_valid=1 set cap_pend=1, go CAPTURE.
  - CAPTURE: load buffer←data_out, idx=0, go SEND.
  - SEND: dout_valid=1; on dout_valid&dout_ready: if idx=NWORDS-1 go IDLE and idx=0, else idx+1.
- busy=1 in CAPTURE and SEND; 0 in IDLE.
- Word order: word k = buffer[W*k +: W] (LSW first) unless the configuration macro is defined.
- dout_last=1 iff SEND and idx=NWORDS-1.
- dout is combinational from buffer and idx; stable while dout_valid=1 and dout_ready=0.
- pre_data_out_valid=1 in CAPTURE or SEND: block dropped, overrun←1. Current block unaffected.
- clr_overrun=1 clears overrun; if an overrun event occurs in the same cycle, set wins.
- Final-word handshake and pre_data_out_valid in the same cycle: treated as overrun (FSM still in SEND). The core must observe busy=0 first.

## Timing
- Cycle t: pre_data_out_valid=1 (IDLE). t+1: CAPTURE, data_out sampled at end of t+1. t+2: dout_valid=1, word0.
- Consumer always ready: NWORDS words in cycles t+2..t+1+NWORDS; IDLE and busy=0 at t+2+NWORDS.
- busy rises at t+1 and falls the cycle after the final handshake.
- Minimum spacing between accepted pre_data_out_valid pulses: NWORDS+2 cycles.
- Reset asserted mid-SEND: immediate return to reset values; partial block discarded, no dout_last.

## Configuration
- CLYDE_OSER_MSW_FIRST_EN defined: word k = buffer[Nbits-W*(k+1) +: W]. MSW goes first and dout_last marks the LSW.
- Not defined: LSW-first order as above.
- Timing, handshakes and flags are identical in both builds.

## Structure
- Shared package clyde_oser_pkg: state enum (IDLE, CAPTURE, SEND) and the NWORDS / index-width derivation function.
- Optional sub-module clyde_oser_wordsel: combinational buffer→word multiplexer holding the CLYDE_OSER_MSW_FIRST_EN ordering. The FSM, counter and flags stay in the top.

## Test plan
- Nominal: data_out=0x00112233_44556677_8899AABB_CCDDEEFF, pulse at t, dout_ready=1 → words 0xCCDDEEFF, 0x8899AABB, 0x44556677, 0x00112233 at t+2..t+5; dout_last only at t+5; busy=0 at t+6.
- Backpressure: dout_ready low for 3 cycles on word1 → dout holds 0x8899AABB with dout_valid=1 throughout; no word skipped or duplicated.
- Overrun: second pulse at t+3 → overrun=1 and stays set; first block completes intact. clr_overrun pulse → overrun=0.
- Simultaneous set/clear: clr_overrun=1 in the same cycle as an overrun event → overrun=1.
- Reset mid-SEND: rst_n low after word1 → all outputs 0 immediately. A new block then streams from word0.
- MSW-first build (CLYDE_OSER_MSW_FIRST_EN): same block → 0x00112233 first; dout_last on 0xCCDDEEFF.
